// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester handshake and register-file write port bundle
interface reg_write_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    Req_Valid;
  logic [5*NUM_REQ-1:0]  Req_Reg;
  logic [32*NUM_REQ-1:0] Req_Data;
  logic [NUM_REQ-1:0]    Req_Ready;
  logic [4:0]            Write_Reg;
  logic [31:0]           Write_Data;
  logic                  Reg_Write;
  logic                  Init_Done;

  modport master (
    output Req_Valid, Req_Reg, Req_Data,
    input  Req_Ready, Write_Reg, Write_Data, Reg_Write, Init_Done
  );

  modport slave (
    input  Req_Valid, Req_Reg, Req_Data,
    output Req_Ready, Write_Reg, Write_Data, Reg_Write, Init_Done
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - register-file write port owner: reset init sweep, then round-robin writeback arbitration
module reg_write_arbiter #(
  parameter int          NUM_REQ = 3,
  parameter int          SP_REG  = 29,
  parameter logic [31:0] SP_INIT = 32'h00001FFF
) (
  input logic               Clock,
  input logic               Reset_n,
  reg_write_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state;
  logic [4:0]         idx;
  logic [PW-1:0]      ptr;
  logic               found;
  logic [PW-1:0]      win;
  logic [PW-1:0]      cand;
  logic [NUM_REQ-1:0] grant;
  logic [4:0]         win_reg;
  logic [31:0]        win_data;

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    grant = '0;
    if (state == ST_RUN) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = PW'((int'(ptr) + k) % NUM_REQ);
        if (!found && bus.Req_Valid[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
    if (found) begin
      grant[win] = 1'b1;
    end
  end

  assign win_reg       = bus.Req_Reg[int'(win)*5 +: 5];
  assign win_data      = bus.Req_Data[int'(win)*32 +: 32];
  assign bus.Req_Ready = grant;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= ST_INIT;
      idx            <= '0;
      ptr            <= PW'(NUM_REQ - 1);
      bus.Reg_Write  <= 1'b0;
      bus.Write_Reg  <= '0;
      bus.Write_Data <= '0;
      bus.Init_Done  <= 1'b0;
    end else if (state == ST_INIT) begin
      bus.Reg_Write  <= 1'b1;
      bus.Write_Reg  <= idx;
      bus.Write_Data <= (idx == 5'(SP_REG)) ? SP_INIT : 32'h0;
      idx            <= idx + 5'd1;
      if (idx == 5'd31) begin
        state         <= ST_RUN;
        bus.Init_Done <= 1'b1;
      end
    end else if (found) begin
      // Writes to $zero are accepted and rotate the pointer but never reach the file.
      bus.Reg_Write  <= (win_reg != 5'd0);
      bus.Write_Reg  <= win_reg;
      bus.Write_Data <= win_data;
      ptr            <= win;
    end else begin
      bus.Reg_Write  <= 1'b0;
    end
  end
endmodule
